// File: rtl/axi_led_reg_arbiter_if.sv
// One requester port of the LED register arbiter: a request channel and a response channel.
// Handshake: a channel transfers on a cycle where valid and ready are both 1; the sender
// holds valid and payload stable until that cycle, and the receiver may drive ready freely.
interface axi_led_reg_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_strb;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_ready;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_strb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_strb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/axi_led_reg_arbiter.sv
// Two-port round-robin arbiter in front of a small register bank; word 0 drives the LEDs.
// Accesses are serialised through IDLE -> ACCESS -> RESP, one response per accepted request.
module axi_led_reg_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int LED_WIDTH  = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    axi_led_reg_arbiter_if.slave  m0,
    axi_led_reg_arbiter_if.slave  m1,
    output logic [LED_WIDTH-1:0]  led_o,
    output logic [1:0]            fsm_state
);
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  bank_we;
    logic [DATA_WIDTH-1:0] bank [DEPTH];

    logic                  g_valid;
    logic                  g_we;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [STRB_WIDTH-1:0] g_strb;
    logic                  g_rsp_ready;
    logic [DATA_WIDTH-1:0] merged;

    // Request fields of whichever port currently holds the grant.
    assign g_valid     = grant_q ? m1.req_valid : m0.req_valid;
    assign g_we        = grant_q ? m1.req_we    : m0.req_we;
    assign g_addr      = grant_q ? m1.req_addr  : m0.req_addr;
    assign g_wdata     = grant_q ? m1.req_wdata : m0.req_wdata;
    assign g_strb      = grant_q ? m1.req_strb  : m0.req_strb;
    assign g_rsp_ready = grant_q ? m1.rsp_ready : m0.rsp_ready;

    // Post-write word: for a read this is simply the current contents.
    always_comb begin
        merged = bank[g_addr];
        if (g_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (g_strb[b]) merged[8*b +: 8] = g_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        bank_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0.req_valid || m1.req_valid) begin
                    if (m0.req_valid && m1.req_valid) grant_d = ~last_grant_q;
                    else                              grant_d = ~m0.req_valid;
                    last_grant_d = grant_d;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (g_valid) begin
                    bank_we    = g_we;
                    rsp_data_d = merged;
                    state_d    = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (g_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else if (bank_we) begin
            bank[g_addr] <= merged;
        end
    end

    assign m0.req_ready = (state_q == ACCESS) && !grant_q;
    assign m1.req_ready = (state_q == ACCESS) &&  grant_q;
    assign m0.rsp_valid = (state_q == RESP)   && !grant_q;
    assign m1.rsp_valid = (state_q == RESP)   &&  grant_q;
    assign m0.rsp_rdata = m0.rsp_valid ? rsp_data_q : '0;
    assign m1.rsp_rdata = m1.rsp_valid ? rsp_data_q : '0;

    assign led_o     = bank[0][LED_WIDTH-1:0];
    assign fsm_state = state_q;
endmodule

// File: tb/tb_axi_led_reg_arbiter.sv
// Bench for axi_led_reg_arbiter: directed scenarios plus randomized two-port traffic,
// checked by a scoreboard fed from a word-array model of the register bank.
module tb_axi_led_reg_arbiter;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int SW = DW / 8;
    localparam int LW = 8;

    logic clk;
    logic rst_n;

    logic          req_valid [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic [SW-1:0] req_strb  [2];
    logic          rsp_ready [2];
    logic          req_ready [2];
    logic          rsp_valid [2];
    logic [DW-1:0] rsp_rdata [2];
    logic [LW-1:0] led_o;
    logic [1:0]    fsm_state;

    axi_led_reg_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
    axi_led_reg_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

    assign if0.req_valid = req_valid[0];
    assign if0.req_we    = req_we[0];
    assign if0.req_addr  = req_addr[0];
    assign if0.req_wdata = req_wdata[0];
    assign if0.req_strb  = req_strb[0];
    assign if0.rsp_ready = rsp_ready[0];
    assign req_ready[0]  = if0.req_ready;
    assign rsp_valid[0]  = if0.rsp_valid;
    assign rsp_rdata[0]  = if0.rsp_rdata;

    assign if1.req_valid = req_valid[1];
    assign if1.req_we    = req_we[1];
    assign if1.req_addr  = req_addr[1];
    assign if1.req_wdata = req_wdata[1];
    assign if1.req_strb  = req_strb[1];
    assign if1.rsp_ready = rsp_ready[1];
    assign req_ready[1]  = if1.req_ready;
    assign rsp_valid[1]  = if1.rsp_valid;
    assign rsp_rdata[1]  = if1.rsp_rdata;

    axi_led_reg_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LED_WIDTH(LW)) dut (
        .ACLK      (clk),
        .ARESETN   (rst_n),
        .m0        (if0),
        .m1        (if1),
        .led_o     (led_o),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] ref_bank [8];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    int            acc_q [$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                                 input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // ---------------- driver ----------------
    // Call at a point away from the rising edge; returns just after the edge that ends ACCESS.
    task automatic do_req(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s, output int waited);
        req_we[p]    = we;
        req_addr[p]  = a;
        req_wdata[p] = d;
        req_strb[p]  = s;
        req_valid[p] = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            waited++;
            if (req_ready[p]) break;
            if (waited > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_timeout: port %0d got no ready required ready within 300 cycles", p);
                req_valid[p] = 1'b0;
                return;
            end
        end
        if (we) ref_bank[a] = apply_strb(ref_bank[a], d, s);
        if (p == 0) exp_q0.push_back(ref_bank[a]);
        else        exp_q1.push_back(ref_bank[a]);
        acc_q.push_back(p);
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    // ---------------- monitor ----------------
    task automatic take_rsp(input int p);
        logic [DW-1:0] e;
        if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: port %0d got %h required no response", p, rsp_rdata[p]);
            return;
        end
        e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check(p == 0 ? "rsp_rdata_m0" : "rsp_rdata_m1", rsp_rdata[p], e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid[0] || rsp_valid[1])
                check("rsp_exclusive", {31'd0, rsp_valid[0] && rsp_valid[1]}, '0);
            if (rsp_valid[0]) check("rdata_ungranted_m1", rsp_rdata[1], '0);
            if (rsp_valid[1]) check("rdata_ungranted_m0", rsp_rdata[0], '0);
            if (rsp_valid[0] && rsp_ready[0]) take_rsp(0);
            if (rsp_valid[1] && rsp_ready[1]) take_rsp(1);
        end
    end

    // ---------------- stimulus ----------------
    int  w;
    int  w0;
    int  w1;
    logic done0;
    logic done1;

    initial begin
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'b0;
            req_we[p]    = 1'b0;
            req_addr[p]  = '0;
            req_wdata[p] = '0;
            req_strb[p]  = '0;
            rsp_ready[p] = 1'b1;
        end
        for (int i = 0; i < 8; i++) ref_bank[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_led", led_o, '0);
        check("reset_state_idle", fsm_state, 0);
        check("reset_ready_m0", req_ready[0], 0);
        check("reset_ready_m1", req_ready[1], 0);
        check("reset_rsp_valid_m0", rsp_valid[0], 0);
        check("reset_rsp_valid_m1", rsp_valid[1], 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic write of word 0: ready in cycle 1, response and LED in cycle 2.
        do_req(0, 1'b1, 3'd0, 32'h0000_00A5, 4'hF, w);
        check("t1_ready_cycle", w, 2);
        @(negedge clk);
        check("t1_ready_single_pulse", req_ready[0], 0);
        check("t1_rsp_valid", rsp_valid[0], 1);
        check("t1_led", led_o, 8'hA5);
        repeat (2) @(posedge clk);
        #1;

        // Byte strobes merge into an existing word.
        do_req(0, 1'b1, 3'd3, 32'h1122_3344, 4'hF, w);
        do_req(0, 1'b1, 3'd3, 32'hAABB_CCDD, 4'h5, w);
        do_req(0, 1'b0, 3'd3, 32'h0, 4'h0, w);
        @(negedge clk);
        check("t2_strobe_merge", rsp_rdata[0], 32'h11BB_33DD);
        repeat (3) @(posedge clk);
        #1;

        // m1 withdraws valid during ACCESS: no write, no response, back to IDLE.
        req_we[1] = 1'b1; req_addr[1] = 3'd5; req_wdata[1] = 32'hDEAD_BEEF; req_strb[1] = 4'hF;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("drop_ready_m1", req_ready[1], 1);
        check("drop_no_rsp_access", rsp_valid[1], 0);
        @(negedge clk);
        check("drop_back_idle", fsm_state, 0);
        check("drop_no_rsp_after", rsp_valid[1], 0);
        repeat (3) begin
            @(negedge clk);
            check("drop_no_rsp_late", rsp_valid[1], 0);
        end
        @(posedge clk);
        #1;

        // Both ports valid continuously: m1 was granted last, so m0 leads and grants alternate.
        acc_q.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) do_req(0, 1'b0, 3'd1, 32'h0, 4'h0, w0);
            end
            begin
                for (int i = 0; i < 4; i++) do_req(1, 1'b1, 3'd1, DW'(i + 1), 4'hF, w1);
            end
        join
        check("rr_accept_count", acc_q.size(), 8);
        for (int i = 0; i < acc_q.size(); i++) check("rr_grant_order", acc_q[i], i % 2);
        repeat (2) @(posedge clk);
        #1;
        do_req(0, 1'b0, 3'd5, 32'h0, 4'h0, w);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset while a write of all-ones to word 0 sits in ACCESS.
        req_we[0] = 1'b1; req_addr[0] = 3'd0; req_wdata[0] = 32'hFFFF_FFFF; req_strb[0] = 4'hF;
        req_valid[0] = 1'b1;
        w = 0;
        while (!req_ready[0] && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rst_reached_access", req_ready[0], 1);
        rst_n = 1'b0;
        #1;
        req_valid[0] = 1'b0;
        check("rst_led", led_o, '0);
        check("rst_state", fsm_state, 0);
        check("rst_ready_m0", req_ready[0], 0);
        check("rst_rsp_valid_m0", rsp_valid[0], 0);
        check("rst_rdata_m0", rsp_rdata[0], '0);
        check("rst_rdata_m1", rsp_rdata[1], '0);
        for (int i = 0; i < 8; i++) ref_bank[i] = '0;
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk);
        #1;
        check("rst_led_held", led_o, '0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        acc_q.delete();
        fork
            do_req(0, 1'b0, 3'd0, 32'h0, 4'h0, w0);
            do_req(1, 1'b0, 3'd0, 32'h0, 4'h0, w1);
        join
        check("rst_first_contest_m0", acc_q[0], 0);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure on m0 for 5 cycles while m1 waits.
        rsp_ready[0] = 1'b0;
        do_req(0, 1'b1, 3'd2, 32'h1234_5678, 4'hF, w);
        req_we[1] = 1'b0; req_addr[1] = 3'd2; req_wdata[1] = '0; req_strb[1] = '0;
        req_valid[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid[0], 1);
            check("bp_rdata_stable", rsp_rdata[0], 32'h1234_5678);
            check("bp_no_ready_m1", req_ready[1], 0);
            if (k == 4) begin
                @(posedge clk);
                #1;
                rsp_ready[0] = 1'b1;
            end
        end
        do_req(1, 1'b0, 3'd2, 32'h0, 4'h0, w);
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic from both ports with random response backpressure.
        done0 = 1'b0;
        done1 = 1'b0;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    do_req(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                           4'($urandom_range(0, 15)), w0);
                end
                done0 = 1'b1;
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    do_req(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                           4'($urandom_range(0, 15)), w1);
                end
                done1 = 1'b1;
            end
            begin
                while (!(done0 && done1)) begin
                    @(posedge clk);
                    #2;
                    rsp_ready[0] = ($urandom_range(0, 3) != 0);
                    rsp_ready[1] = ($urandom_range(0, 3) != 0);
                end
                rsp_ready[0] = 1'b1;
                rsp_ready[1] = 1'b1;
            end
        join
        check("led_tracks_word0", led_o, ref_bank[0][LW-1:0]);

        w = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && w < 100) begin
            @(posedge clk);
            w++;
        end
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_led_reg_arbiter.md
# axi_led_reg_arbiter

Two-port round-robin arbiter and storage controller for the LED register bank. It shares a 2^ADDR_WIDTH x DATA_WIDTH register bank between two independent requesters, for example the AXI slave front end and a local pattern engine. It serialises single-beat read/write accesses with valid/ready handshakes and returns one response per access to the requester that issued it. Register 0 drives the board LEDs.

## Interface
- DATA_WIDTH, 32, register and data bus width; must be a multiple of 8
- ADDR_WIDTH, 3, word address width; the bank holds 8 words by default
- LED_WIDTH, 8, number of LED outputs; must be <= DATA_WIDTH

- ACLK  in  1  clock; all logic is rising-edge
- ARESETN  in  1  asynchronous, active-low reset
- mN_req_valid  in  1  request valid, N in {0,1}
- mN_req_ready  out  1  request accepted this cycle
- mN_req_we  in  1  1 = write, 0 = read
- mN_req_addr  in  ADDR_WIDTH  word address
- mN_req_wdata  in  DATA_WIDTH  write data
- mN_req_strb  in  DATA_WIDTH/8  byte write enables; ignored for reads
- mN_rsp_valid  out  1  response valid
- mN_rsp_rdata  out  DATA_WIDTH  read data, or post-write contents of the addressed word
- mN_rsp_ready  in  1  response accepted
- led_o  out  LED_WIDTH  equals bank[0][LED_WIDTH-1:0]

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE
  - If no mN_req_valid is set: stay in IDLE.
  - Otherwise register the grant and go to ACCESS.
  - Arbitration is round-robin. When both requesters are valid, grant the one not granted last.
  - The last_grant pointer resets to 1, so m0 wins the first contest.
  - Update last_grant when the grant is registered.
- ACCESS
  - Assert mG_req_ready for the granted requester G, for exactly one cycle.
  - If mG_req_valid=1:
    - Sample we, addr, wdata and strb.
    - On a write, update each byte of bank[addr] whose strb bit is set.
    - Register the response data as the post-write value of bank[addr].
    - Go to RESP.
  - If mG_req_valid=0 (protocol violation): no access, no response, go to IDLE. last_grant keeps its updated value.
- RESP
  - Hold mG_rsp_valid=1 with stable mG_rsp_rdata until mG_rsp_ready=1.
  - In that cycle, go to IDLE.
- The non-granted requester sees req_ready=0 and rsp_valid=0 throughout.
- Requests stay pending while valid is held. A requester must keep valid, address and data stable until it sees ready.
- Accesses are serialised, so the bank never sees simultaneous writes.
- rsp_rdata of a non-granted port is 0.
- led_o is driven combinationally from register bit state, with no extra logic.
- Out-of-range addresses cannot occur: the bank is fully decoded at 2^ADDR_WIDTH words.

## Timing
- Reset (ARESETN=0, asynchronous, at any point including mid-transaction):
  - State goes to IDLE and last_grant to 1.
  - All bank words, led_o, every req_ready, every rsp_valid and every rsp_rdata go to 0.
  - An in-flight access is discarded.
- Latency per transaction with rsp_ready tied high:
  - Cycle 0: IDLE sees valid and registers the grant.
  - Cycle 1: ACCESS, req_ready=1, bank updated at the end of the cycle.
  - Cycle 2: RESP, rsp_valid=1.
  - Cycle 3: IDLE.
  - Minimum 3 cycles per access; peak throughput is 1 access per 3 cycles.
- A write is visible on led_o on the cycle after ACCESS, coincident with rsp_valid.
- Backpressure: each cycle rsp_ready is held 0 extends RESP by one cycle. No new grant is issued during that time.
- Both requesters valid continuously: grants alternate m0, m1, m0, ...
- A valid held by the non-granted requester is served on the next IDLE, so starvation is bounded to one transaction.

## Test plan
- Reset, then m0 writes addr 0, data 0x000000A5, strb 0xF:
  - mN_req_ready pulses in cycle 1.
  - rsp_valid rises in cycle 2 with rdata 0x000000A5.
  - led_o becomes 0xA5 in cycle 2.
- Write addr 3 with 0x11223344 strb 0xF, then addr 3 with 0xAABBCCDD strb 0x5, then read addr 3:
  - The read returns 0x11BB33DD.
- m0 and m1 both hold valid for 4 transactions each (m0 reads addr 1, m1 writes addr 1 = i):
  - Grant order is m0, m1, m0, m1, ...
  - Each m0 read returns the preceding m1 write.
  - There are no dropped or duplicate responses.
- Granted requester's rsp_ready held 0 for 5 cycles while the other requester is valid:
  - rsp_valid and rdata stay stable for 6 cycles.
  - The other requester gets no ready until RESP exits.
- ARESETN asserted in ACCESS during a write of 0xFFFFFFFF to addr 0:
  - All outputs go to 0 immediately.
  - After release, a read of addr 0 returns 0 and m0 wins the first contested grant.
- m1 drops valid in the ACCESS cycle:
  - No bank change and no rsp_valid.
  - The FSM is back in IDLE the next cycle.
